// File: rtl/sram_host_arbiter_pkg.sv
// Shared types and defaults for the SRAM host arbiter: FSM state encodings
// and the default boot configuration address.
package sram_arb_pkg;
    localparam logic [20:0] DEF_CFG_ADDR = 21'h008FD5;

    typedef logic [2:0] state_t;
    localparam state_t BOOT    = 3'd0;
    localparam state_t RUN     = 3'd1;
    localparam state_t HGRANT  = 3'd2;
    localparam state_t HACCESS = 3'd3;
    localparam state_t HDONE   = 3'd4;
endpackage

// File: rtl/sram_host_arbiter_if.sv
// Machine, host and SRAM pad signals of the arbiter, bundled as one interface.
// The slave modport is the arbiter's view; master is the environment's view.
interface sram_host_arbiter_if;
    logic [18:0] sam_addr;
    logic        sam_we_n;
    logic [7:0]  sam_wdata;
    logic        sam_free;
    logic        host_req;
    logic        host_we;
    logic [20:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic [20:0] sram_addr;
    logic        sram_we_n;
    logic [7:0]  sram_data_out;
    logic        sram_data_oe;
    logic [7:0]  sram_data_in;

    modport slave (
        input  sam_addr, sam_we_n, sam_wdata, sam_free,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output sram_addr, sram_we_n, sram_data_out, sram_data_oe,
        input  sram_data_in
    );

    modport master (
        output sam_addr, sam_we_n, sam_wdata, sam_free,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  sram_addr, sram_we_n, sram_data_out, sram_data_oe,
        output sram_data_in
    );
endinterface

// File: rtl/sram_host_arbiter.sv
// Owns the external SRAM port: boot-time config read, zero-latency machine
// pass-through, and single-byte host transfers slotted into machine-free windows.
module sram_host_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [20:0] CFG_ADDR    = DEF_CFG_ADDR,
    parameter int          BOOT_CYCLES = 7,
    parameter int          HOST_CYCLES = 2,
    parameter logic [1:0]  SAM_BANK    = 2'b00
) (
    input  logic                      clk,
    input  logic                      reset_n,
    sram_host_arbiter_if.slave        bus,
    output logic [1:0]                cfg_out,
    output logic                      machine_reset_n
);
    localparam int MAXC = (BOOT_CYCLES > HOST_CYCLES) ? BOOT_CYCLES : HOST_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [20:0]   r_haddr;
    logic          r_hwe;
    logic [7:0]    r_hwdata;
    logic          r_ack;
    logic [7:0]    r_rdata;
    logic [1:0]    r_cfg;
    logic          r_mrst_n;

    logic w_boot_done;
    logic w_hlast;

    assign w_boot_done = (r_cnt == CW'(BOOT_CYCLES - 1));
    assign w_hlast     = (r_cnt == CW'(HOST_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= BOOT;
            r_cnt    <= '0;
            r_haddr  <= '0;
            r_hwe    <= 1'b0;
            r_hwdata <= '0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_cfg    <= 2'b00;
            r_mrst_n <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_cfg <= bus.sram_data_in[1:0];
                    if (w_boot_done) begin
                        r_state  <= RUN;
                        r_cnt    <= '0;
                        r_mrst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (bus.host_req && bus.sam_free) begin
                        r_state  <= HGRANT;
                        r_haddr  <= bus.host_addr;
                        r_hwe    <= bus.host_we;
                        r_hwdata <= bus.host_wdata;
                    end
                end
                HGRANT: begin
                    r_state <= HACCESS;
                    r_cnt   <= '0;
                end
                HACCESS: begin
                    if (w_hlast) begin
                        r_state <= HDONE;
                        r_cnt   <= '0;
                        r_ack   <= 1'b1;
                        if (!r_hwe) r_rdata <= bus.sram_data_in;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                HDONE:   r_state <= RUN;
                default: begin
                    r_state <= BOOT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Write strobe is released on the final access cycle so data holds past we_n rising.
    always_comb begin
        bus.sram_addr     = CFG_ADDR;
        bus.sram_we_n     = 1'b1;
        bus.sram_data_out = bus.sam_wdata;
        bus.sram_data_oe  = 1'b0;
        case (r_state)
            RUN, HDONE: begin
                bus.sram_addr    = {SAM_BANK, bus.sam_addr};
                bus.sram_we_n    = bus.sam_we_n;
                bus.sram_data_oe = ~bus.sam_we_n;
            end
            HGRANT: begin
                bus.sram_addr     = r_haddr;
                bus.sram_data_out = r_hwdata;
                bus.sram_data_oe  = r_hwe;
            end
            HACCESS: begin
                bus.sram_addr     = r_haddr;
                bus.sram_we_n     = ~(r_hwe & ~w_hlast);
                bus.sram_data_out = r_hwdata;
                bus.sram_data_oe  = r_hwe;
            end
            default: ;
        endcase
    end

    assign bus.host_ack   = r_ack;
    assign bus.host_rdata = r_rdata;
    assign cfg_out        = r_cfg;
    assign machine_reset_n = r_mrst_n;
endmodule

// File: tb/tb_sram_host_arbiter.sv
// Directed bench for sram_host_arbiter: boot config read, pass-through,
// host read/write slotting, starvation without sam_free, and reset mid-write.
module tb_sram_host_arbiter;
    logic       clk;
    logic       reset_n;
    logic [1:0] cfg_out;
    logic       machine_reset_n;
    int         tests;
    int         fails;

    sram_host_arbiter_if bus();

    sram_host_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .cfg_out         (cfg_out),
        .machine_reset_n (machine_reset_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Releases reset between edges, then walks the 7 boot cycles.
    task automatic boot_seq(input logic [1:0] exp_cfg);
        int early_rst;
        int bad_addr;
        int acks;
        early_rst = 0;
        bad_addr  = 0;
        acks      = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (bus.sram_addr !== 21'h008FD5 || bus.sram_we_n !== 1'b1) bad_addr++;
            tick();
            if (i < 7 && machine_reset_n !== 1'b0) early_rst++;
            if (bus.host_ack !== 1'b0) acks++;
        end
        chk("boot_addr_held", bad_addr, 0);
        chk("boot_rst_early", early_rst, 0);
        chk("boot_rst_cycle7", machine_reset_n, 1'b1);
        chk("boot_no_ack", acks, 0);
        chk("boot_cfg", cfg_out, exp_cfg);
    endtask

    initial begin
        int bad;
        int acks;
        int grants;
        logic [18:0] a;
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        bus.sam_addr = '0; bus.sam_we_n = 1'b1; bus.sam_wdata = '0; bus.sam_free = 1'b0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.sram_data_in = 8'hA7;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", bus.sram_addr, 21'h008FD5);
        chk("rst_we_n", bus.sram_we_n, 1'b1);
        chk("rst_oe", bus.sram_data_oe, 1'b0);
        chk("rst_mrst", machine_reset_n, 1'b0);
        chk("rst_cfg", cfg_out, 2'b00);
        chk("rst_ack", bus.host_ack, 1'b0);
        chk("rst_rdata", bus.host_rdata, 8'h00);

        boot_seq(2'b11);

        // Machine pass-through, same cycle
        bus.sam_addr = 19'h12345; bus.sam_we_n = 1'b0; bus.sam_wdata = 8'h99;
        #1;
        chk("pt_addr", bus.sram_addr, 21'h012345);
        chk("pt_we_n", bus.sram_we_n, 1'b0);
        chk("pt_oe", bus.sram_data_oe, 1'b1);
        chk("pt_dout", bus.sram_data_out, 8'h99);
        bus.sram_data_in = 8'h00;
        tick();
        chk("cfg_frozen", cfg_out, 2'b11);

        // Host read; machine write in the free-flag cycle still passes through
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 21'h1F0000;
        bus.sam_free = 1'b1; bus.sam_addr = 19'h00042; bus.sam_we_n = 1'b0;
        bus.sram_data_in = 8'h5C;
        #1;
        chk("free_wr_addr", bus.sram_addr, 21'h000042);
        chk("free_wr_we_n", bus.sram_we_n, 1'b0);
        tick();
        bus.sam_free = 1'b0; bus.sam_we_n = 1'b0; bus.sam_addr = 19'h7FFFF;
        bus.host_req = 1'b0;
        #1;
        chk("rd_grant_addr", bus.sram_addr, 21'h1F0000);
        chk("rd_grant_we_n", bus.sram_we_n, 1'b1);
        chk("rd_grant_oe", bus.sram_data_oe, 1'b0);
        chk("rd_grant_ack", bus.host_ack, 1'b0);
        tick();
        chk("rd_acc0_addr", bus.sram_addr, 21'h1F0000);
        chk("rd_acc0_we_n", bus.sram_we_n, 1'b1);
        tick();
        chk("rd_acc1_ack", bus.host_ack, 1'b0);
        tick();
        chk("rd_ack", bus.host_ack, 1'b1);
        chk("rd_data", bus.host_rdata, 8'h5C);
        chk("rd_done_passthru", bus.sram_addr, 21'h07FFFF);
        bus.sram_data_in = 8'h00; bus.sam_we_n = 1'b1;
        tick();
        chk("rd_ack_pulse", bus.host_ack, 1'b0);
        chk("rd_data_hold", bus.host_rdata, 8'h5C);

        // Host write, host_req held through ack
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 21'h1F0001;
        bus.host_wdata = 8'h3E; bus.sam_free = 1'b1;
        tick();
        bus.sam_free = 1'b0;
        #1;
        chk("wr_grant_addr", bus.sram_addr, 21'h1F0001);
        chk("wr_grant_we_n", bus.sram_we_n, 1'b1);
        chk("wr_grant_oe", bus.sram_data_oe, 1'b1);
        tick();
        chk("wr_acc0_we_n", bus.sram_we_n, 1'b0);
        chk("wr_acc0_dout", bus.sram_data_out, 8'h3E);
        chk("wr_acc0_oe", bus.sram_data_oe, 1'b1);
        chk("wr_acc0_addr", bus.sram_addr, 21'h1F0001);
        tick();
        chk("wr_acc1_we_n", bus.sram_we_n, 1'b1);
        chk("wr_acc1_oe", bus.sram_data_oe, 1'b1);
        chk("wr_acc1_ack", bus.host_ack, 1'b0);
        tick();
        chk("wr_ack", bus.host_ack, 1'b1);
        chk("wr_rdata_kept", bus.host_rdata, 8'h5C);

        // No back-to-back grant; 1000 cycles of host_req without sam_free
        bad = 0; acks = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            a = 19'($urandom);
            bus.sam_addr = a; bus.sam_we_n = 1'($urandom);
            #1;
            if (bus.sram_addr !== {2'b00, a} || bus.sram_we_n !== bus.sam_we_n) bad++;
            if (bus.host_ack !== 1'b0) acks++;
        end
        chk("starve_track", bad, 0);
        chk("starve_no_ack", acks, 0);

        // sam_free without host_req has no effect
        bus.host_req = 1'b0; bus.sam_free = 1'b1; bad = 0; grants = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.sam_addr = 19'(i * 19'h1111);
            #1;
            if (bus.sram_addr !== {2'b00, 19'(i * 19'h1111)}) grants++;
        end
        chk("free_no_req", grants, 0);
        bus.sam_free = 1'b0; bus.sam_we_n = 1'b1;

        // Reset in the middle of a host write
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 21'h1F0003;
        bus.host_wdata = 8'hC1; bus.sam_free = 1'b1;
        tick();
        bus.sam_free = 1'b0;
        tick();
        chk("mid_we_low", bus.sram_we_n, 1'b0);
        bus.sram_data_in = 8'h02;
        bus.host_we = 1'b0; bus.host_addr = 21'h1F0002;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we_n", bus.sram_we_n, 1'b1);
        chk("mid_rst_oe", bus.sram_data_oe, 1'b0);
        chk("mid_rst_mrst", machine_reset_n, 1'b0);
        chk("mid_rst_cfg", cfg_out, 2'b00);
        tick();
        chk("mid_rst_no_ack", bus.host_ack, 1'b0);

        // Host request pending across boot is served after it
        bus.sam_free = 1'b1;
        boot_seq(2'b10);
        tick();
        bus.sam_free = 1'b0;
        #1;
        chk("boot_wait_grant", bus.sram_addr, 21'h1F0002);
        bus.host_req = 1'b0;
        tick();
        tick();
        tick();
        chk("boot_wait_ack", bus.host_ack, 1'b1);
        chk("boot_wait_rdata", bus.host_rdata, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
